pipe_reg_ctrl: RTL and testbench

Central sequencer for the CPU's pipeline registers and PC register: generates the per-stage `enable` and flush controls for every 32-bit enable/reset register in the five-stage pipe. It resolves load-use, multiply/divide busy, taken-branch and syscall-halt events by priority, and runs a halt/resume FSM and an MDU watchdog. It sits between hazard detection/EX-stage outputs and the `enable` pins of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/edge_detect_rise.sv | 21 ++
 rtl/pipe_reg_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_reg_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline register sequencer:
// FSM state encodings and the per-stage control bundle.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MDU_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } ctl_t;

    localparam ctl_t CTL_NORMAL = 8'b11111_000;
    localparam ctl_t CTL_FREEZE = 8'b00000_000;
    localparam ctl_t CTL_LU     = 8'b00111_010;
    localparam ctl_t CTL_MDU    = 8'b00011_001;
    localparam ctl_t CTL_BR     = 8'b11111_110;

endpackage

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector for the resume button.
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/pipe_reg_ctrl.sv
// Pipeline register enable/flush sequencer with halt FSM and MDU watchdog.
// Optional statistics counters are built when PIPE_STATS_EN is defined.
module pipe_reg_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             mdu_busy,
    input  logic             halt_req,
    input  logic             go,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       state,
    output logic             wdog_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MW = $clog2(MDU_TIMEOUT + 1);

    state_e        r_state;
    state_e        w_next;
    logic [MW-1:0] r_mdu_cnt;
    logic [MW-1:0] w_mdu_cnt_nxt;
    logic          r_wdog;
    logic          w_wdog_set;
    logic          w_br_win;
    logic          w_go_rise;
    ctl_t          w_ctl;

    edge_detect_rise u_go_edge (
        .clk    (clk),
        .rst    (rst),
        .i_d    (go),
        .o_rise (w_go_rise)
    );

    always_comb begin
        w_ctl         = CTL_NORMAL;
        w_next        = r_state;
        w_mdu_cnt_nxt = r_mdu_cnt;
        w_wdog_set    = 1'b0;
        w_br_win      = 1'b0;
        case (r_state)
            ST_HALT: begin
                w_ctl = CTL_FREEZE;
                if (w_go_rise) begin
                    w_next = ST_RUN;
                end
            end
            default: begin
                if (r_state == ST_MDU_WAIT && mdu_busy) begin
                    w_ctl         = CTL_MDU;
                    w_mdu_cnt_nxt = r_mdu_cnt + MW'(1);
                    if (r_mdu_cnt == MW'(MDU_TIMEOUT - 1)) begin
                        w_next     = ST_HALT;
                        w_wdog_set = 1'b1;
                    end
                end else begin
                    // branch outranks load_use: the flushed slot holds the consumer
                    w_next = ST_RUN;
                    if (halt_req) begin
                        w_ctl  = CTL_FREEZE;
                        w_next = ST_HALT;
                    end else if (mdu_busy) begin
                        w_ctl         = CTL_MDU;
                        w_next        = ST_MDU_WAIT;
                        w_mdu_cnt_nxt = MW'(1);
                    end else if (branch_taken) begin
                        w_ctl    = CTL_BR;
                        w_br_win = 1'b1;
                    end else if (load_use) begin
                        w_ctl = CTL_LU;
                    end
                end
            end
        endcase
        if (rst) begin
            w_ctl = CTL_FREEZE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_mdu_cnt <= '0;
            r_wdog    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_mdu_cnt <= w_mdu_cnt_nxt;
            if (w_wdog_set) begin
                r_wdog <= 1'b1;
            end
        end
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_ctl.pc_en && r_state != ST_HALT) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_br_win) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    assign pc_en       = w_ctl.pc_en;
    assign ifid_en     = w_ctl.ifid_en;
    assign idex_en     = w_ctl.idex_en;
    assign exmem_en    = w_ctl.exmem_en;
    assign memwb_en    = w_ctl.memwb_en;
    assign ifid_flush  = w_ctl.ifid_flush;
    assign idex_flush  = w_ctl.idex_flush;
    assign exmem_flush = w_ctl.exmem_flush;
    assign state       = r_state;
    assign wdog_err    = r_wdog;

endmodule

// File: tb/tb_pipe_reg_ctrl.sv
// Scoreboard bench for pipe_reg_ctrl with MDU_TIMEOUT=8.
module tb_pipe_reg_ctrl;

    localparam int T = 8;

`ifdef PIPE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [7:0] N   = 8'b11111_000;
    localparam logic [7:0] FRZ = 8'b00000_000;
    localparam logic [7:0] LU  = 8'b00111_010;
    localparam logic [7:0] MDU = 8'b00011_001;
    localparam logic [7:0] BR  = 8'b11111_110;
    localparam logic [1:0] RUN = 2'b00;
    localparam logic [1:0] WT  = 2'b01;
    localparam logic [1:0] HLT = 2'b10;

    // in = {rst, halt_req, mdu_busy, load_use, branch_taken, go}
    typedef struct packed {
        logic [5:0] in;
        logic [7:0] ctl;
        logic [1:0] st;
        logic       wd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_use = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mdu_busy = 1'b0;
    logic        halt_req = 1'b0;
    logic        go = 1'b0;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic [1:0]  state;
    logic        wdog_err;
    logic [31:0] stall_cnt, flush_cnt;
    logic [7:0]  w_ctl;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_stall = '0;
    logic [31:0] exp_flush = '0;
    vec_t        sb[$];

    always #5 clk = ~clk;

    pipe_reg_ctrl #(.MDU_TIMEOUT(T), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .mdu_busy     (mdu_busy),
        .halt_req     (halt_req),
        .go           (go),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .state        (state),
        .wdog_err     (wdog_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign w_ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush};

    function automatic vec_t mk(input logic [5:0] in, input logic [7:0] c,
                                input logic [1:0] s, input logic w);
        mk = {in, c, s, w};
    endfunction

    // Drive one cycle of stimulus and queue what the DUT must show for it.
    task automatic apply(input vec_t v);
        @(negedge clk);
        {rst, halt_req, mdu_busy, load_use, branch_taken, go} = v.in;
        sb.push_back(v);
        #2;
    endtask

    // Counters advance at the edge closing a cycle, from the expected bundle.
    task automatic account(input vec_t e);
        if (e.in[5]) begin
            exp_stall = '0;
            exp_flush = '0;
        end else begin
            if (!e.ctl[7] && e.st != HLT) exp_stall = exp_stall + 1;
            if (e.ctl[2]) exp_flush = exp_flush + 1;
        end
    endtask

    task automatic test_reset();
        vec_t vs[$];
        vec_t e;
        vs.push_back(mk(6'b100000, FRZ, RUN, 1'b0));
        vs.push_back(mk(6'b100000, FRZ, RUN, 1'b0));
        vs.push_back(mk(6'b000000, N, RUN, 1'b0));
        vs.push_back(mk(6'b000000, N, RUN, 1'b0));
        foreach (vs[i]) begin
            apply(vs[i]);
            e = sb.pop_front();
            checks += 5;
            if (w_ctl !== e.ctl) begin failures++; $display("FAIL reset.ctl[%0d] got=%b exp=%b", i, w_ctl, e.ctl); end
            if (state !== e.st) begin failures++; $display("FAIL reset.state[%0d] got=%b exp=%b", i, state, e.st); end
            if (wdog_err !== e.wd) begin failures++; $display("FAIL reset.wdog[%0d] got=%b exp=%b", i, wdog_err, e.wd); end
            if (stall_cnt !== (STATS ? exp_stall : 32'd0)) begin failures++; $display("FAIL reset.stall[%0d] got=%0d exp=%0d", i, stall_cnt, STATS ? exp_stall : 32'd0); end
            if (flush_cnt !== (STATS ? exp_flush : 32'd0)) begin failures++; $display("FAIL reset.flush[%0d] got=%0d exp=%0d", i, flush_cnt, STATS ? exp_flush : 32'd0); end
            account(e);
        end
    endtask

    task automatic test_load_use();
        vec_t vs[$];
        vec_t e;
        vs.push_back(mk(6'b000100, LU, RUN, 1'b0));
        vs.push_back(mk(6'b000000, N, RUN, 1'b0));
        vs.push_back(mk(6'b000110, BR, RUN, 1'b0));
        vs.push_back(mk(6'b000010, BR, RUN, 1'b0));
        vs.push_back(mk(6'b000000, N, RUN, 1'b0));
        foreach (vs[i]) begin
            apply(vs[i]);
            e = sb.pop_front();
            checks += 5;
            if (w_ctl !== e.ctl) begin failures++; $display("FAIL lu.ctl[%0d] got=%b exp=%b", i, w_ctl, e.ctl); end
            if (state !== e.st) begin failures++; $display("FAIL lu.state[%0d] got=%b exp=%b", i, state, e.st); end
            if (wdog_err !== e.wd) begin failures++; $display("FAIL lu.wdog[%0d] got=%b exp=%b", i, wdog_err, e.wd); end
            if (stall_cnt !== (STATS ? exp_stall : 32'd0)) begin failures++; $display("FAIL lu.stall[%0d] got=%0d exp=%0d", i, stall_cnt, STATS ? exp_stall : 32'd0); end
            if (flush_cnt !== (STATS ? exp_flush : 32'd0)) begin failures++; $display("FAIL lu.flush[%0d] got=%0d exp=%0d", i, flush_cnt, STATS ? exp_flush : 32'd0); end
            account(e);
        end
    endtask

    task automatic test_mdu();
        vec_t vs[$];
        vec_t e;
        vs.push_back(mk(6'b001000, MDU, RUN, 1'b0));
        for (int k = 0; k < 4; k++) vs.push_back(mk(6'b001000, MDU, WT, 1'b0));
        vs.push_back(mk(6'b000000, N, WT, 1'b0));
        vs.push_back(mk(6'b000000, N, RUN, 1'b0));
        foreach (vs[i]) begin
            apply(vs[i]);
            e = sb.pop_front();
            checks += 5;
            if (w_ctl !== e.ctl) begin failures++; $display("FAIL mdu.ctl[%0d] got=%b exp=%b", i, w_ctl, e.ctl); end
            if (state !== e.st) begin failures++; $display("FAIL mdu.state[%0d] got=%b exp=%b", i, state, e.st); end
            if (wdog_err !== e.wd) begin failures++; $display("FAIL mdu.wdog[%0d] got=%b exp=%b", i, wdog_err, e.wd); end
            if (stall_cnt !== (STATS ? exp_stall : 32'd0)) begin failures++; $display("FAIL mdu.stall[%0d] got=%0d exp=%0d", i, stall_cnt, STATS ? exp_stall : 32'd0); end
            if (flush_cnt !== (STATS ? exp_flush : 32'd0)) begin failures++; $display("FAIL mdu.flush[%0d] got=%0d exp=%0d", i, flush_cnt, STATS ? exp_flush : 32'd0); end
            account(e);
        end
    endtask

    task automatic test_halt();
        vec_t vs[$];
        vec_t e;
        vs.push_back(mk(6'b000001, N, RUN, 1'b0));
        vs.push_back(mk(6'b011001, FRZ, RUN, 1'b0));
        vs.push_back(mk(6'b000001, FRZ, HLT, 1'b0));
        vs.push_back(mk(6'b000001, FRZ, HLT, 1'b0));
        vs.push_back(mk(6'b000000, FRZ, HLT, 1'b0));
        vs.push_back(mk(6'b000001, FRZ, HLT, 1'b0));
        vs.push_back(mk(6'b000001, N, RUN, 1'b0));
        vs.push_back(mk(6'b000000, N, RUN, 1'b0));
        foreach (vs[i]) begin
            apply(vs[i]);
            e = sb.pop_front();
            checks += 5;
            if (w_ctl !== e.ctl) begin failures++; $display("FAIL halt.ctl[%0d] got=%b exp=%b", i, w_ctl, e.ctl); end
            if (state !== e.st) begin failures++; $display("FAIL halt.state[%0d] got=%b exp=%b", i, state, e.st); end
            if (wdog_err !== e.wd) begin failures++; $display("FAIL halt.wdog[%0d] got=%b exp=%b", i, wdog_err, e.wd); end
            if (stall_cnt !== (STATS ? exp_stall : 32'd0)) begin failures++; $display("FAIL halt.stall[%0d] got=%0d exp=%0d", i, stall_cnt, STATS ? exp_stall : 32'd0); end
            if (flush_cnt !== (STATS ? exp_flush : 32'd0)) begin failures++; $display("FAIL halt.flush[%0d] got=%0d exp=%0d", i, flush_cnt, STATS ? exp_flush : 32'd0); end
            account(e);
        end
    endtask

    task automatic test_back_to_back();
        vec_t vs[$];
        vec_t e;
        vs.push_back(mk(6'b001000, MDU, RUN, 1'b0));
        vs.push_back(mk(6'b011000, MDU, WT, 1'b0));
        vs.push_back(mk(6'b010000, FRZ, WT, 1'b0));
        vs.push_back(mk(6'b000001, FRZ, HLT, 1'b0));
        vs.push_back(mk(6'b000000, N, RUN, 1'b0));
        vs.push_back(mk(6'b001000, MDU, RUN, 1'b0));
        vs.push_back(mk(6'b000110, BR, WT, 1'b0));
        vs.push_back(mk(6'b001000, MDU, RUN, 1'b0));
        vs.push_back(mk(6'b001000, MDU, WT, 1'b0));
        vs.push_back(mk(6'b000100, LU, WT, 1'b0));
        vs.push_back(mk(6'b001000, MDU, RUN, 1'b0));
        vs.push_back(mk(6'b101000, FRZ, WT, 1'b0));
        vs.push_back(mk(6'b000000, N, RUN, 1'b0));
        foreach (vs[i]) begin
            apply(vs[i]);
            e = sb.pop_front();
            checks += 5;
            if (w_ctl !== e.ctl) begin failures++; $display("FAIL b2b.ctl[%0d] got=%b exp=%b", i, w_ctl, e.ctl); end
            if (state !== e.st) begin failures++; $display("FAIL b2b.state[%0d] got=%b exp=%b", i, state, e.st); end
            if (wdog_err !== e.wd) begin failures++; $display("FAIL b2b.wdog[%0d] got=%b exp=%b", i, wdog_err, e.wd); end
            if (stall_cnt !== (STATS ? exp_stall : 32'd0)) begin failures++; $display("FAIL b2b.stall[%0d] got=%0d exp=%0d", i, stall_cnt, STATS ? exp_stall : 32'd0); end
            if (flush_cnt !== (STATS ? exp_flush : 32'd0)) begin failures++; $display("FAIL b2b.flush[%0d] got=%0d exp=%0d", i, flush_cnt, STATS ? exp_flush : 32'd0); end
            account(e);
        end
    endtask

    task automatic test_watchdog();
        vec_t vs[$];
        vec_t e;
        vs.push_back(mk(6'b001000, MDU, RUN, 1'b0));
        for (int k = 1; k < T; k++) vs.push_back(mk(6'b001000, MDU, WT, 1'b0));
        vs.push_back(mk(6'b001000, FRZ, HLT, 1'b1));
        vs.push_back(mk(6'b001000, FRZ, HLT, 1'b1));
        vs.push_back(mk(6'b000000, FRZ, HLT, 1'b1));
        vs.push_back(mk(6'b100000, FRZ, HLT, 1'b1));
        vs.push_back(mk(6'b000000, N, RUN, 1'b0));
        vs.push_back(mk(6'b000000, N, RUN, 1'b0));
        foreach (vs[i]) begin
            apply(vs[i]);
            e = sb.pop_front();
            checks += 5;
            if (w_ctl !== e.ctl) begin failures++; $display("FAIL wdog.ctl[%0d] got=%b exp=%b", i, w_ctl, e.ctl); end
            if (state !== e.st) begin failures++; $display("FAIL wdog.state[%0d] got=%b exp=%b", i, state, e.st); end
            if (wdog_err !== e.wd) begin failures++; $display("FAIL wdog.err[%0d] got=%b exp=%b", i, wdog_err, e.wd); end
            if (stall_cnt !== (STATS ? exp_stall : 32'd0)) begin failures++; $display("FAIL wdog.stall[%0d] got=%0d exp=%0d", i, stall_cnt, STATS ? exp_stall : 32'd0); end
            if (flush_cnt !== (STATS ? exp_flush : 32'd0)) begin failures++; $display("FAIL wdog.flush[%0d] got=%0d exp=%0d", i, flush_cnt, STATS ? exp_flush : 32'd0); end
            account(e);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mdu();
        test_halt();
        test_back_to_back();
        test_watchdog();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard.leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
